game_seq_ctrl: RTL and testbench

//  Parametrised main controller FSM for the sequence-memory game. Coordinates FPGA

---
 rtl/game_pkg.sv | 22 ++
 rtl/game_seq_ctrl_if.sv | 45 ++++
 rtl/game_timeout_cnt.sv | 41 ++++
 rtl/game_seq_ctrl.sv | 179 +++++++++++++++++
 tb/tb_game_seq_ctrl.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the sequence-memory game controller: state encodings and default parameters.
// Optional lives feature enabled with GAME_CTRL_LIVES_EN.
package game_pkg;

    localparam int DEF_ROUNDS_MAX  = 16;
    localparam int DEF_TIMEOUT_CYC = 50000000;
`ifdef GAME_CTRL_LIVES_EN
    localparam int DEF_LIVES       = 3;
`endif

    typedef enum logic [2:0] {
        ST_INIT       = 3'd0,
        ST_SETUP      = 3'd1,
        ST_PLAY_FPGA  = 3'd2,
        ST_PLAY_USER  = 3'd3,
        ST_CHECK      = 3'd4,
        ST_NEXT_ROUND = 3'd5,
        ST_RESULT     = 3'd6,
        ST_RETRY      = 3'd7
    } state_e;

endpackage

// File: rtl/game_seq_ctrl_if.sv
// Handshake and strobe bundle between the game controller and its I/O / datapath.
// lives_left exists only when GAME_CTRL_LIVES_EN is defined.
interface game_seq_ctrl_if #(
    parameter int RW = 5
`ifdef GAME_CTRL_LIVES_EN
   ,parameter int LW = 2
`endif
);
    logic          enter;
    logic          end_fpga;
    logic          end_user;
    logic          match;
    logic          clr_all;
    logic          clr_user;
    logic          en_setup;
    logic          en_fpga;
    logic          en_user;
    logic          en_check;
    logic          sel_result;
    logic [RW-1:0] round;
    logic          won;
    logic          timed_out;
`ifdef GAME_CTRL_LIVES_EN
    logic [LW-1:0] lives_left;
`endif

    modport master (
        output enter, end_fpga, end_user, match,
        input  clr_all, clr_user, en_setup, en_fpga, en_user, en_check, sel_result,
               round, won, timed_out
`ifdef GAME_CTRL_LIVES_EN
             , lives_left
`endif
    );

    modport slave (
        input  enter, end_fpga, end_user, match,
        output clr_all, clr_user, en_setup, en_fpga, en_user, en_check, sel_result,
               round, won, timed_out
`ifdef GAME_CTRL_LIVES_EN
             , lives_left
`endif
    );

endinterface

// File: rtl/game_timeout_cnt.sv
// User-move timeout counter: synchronous load to zero, count enable, terminal-count flag
// raised when the count reaches TIMEOUT_CYC-1.
module game_timeout_cnt #(
    parameter int TIMEOUT_CYC = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic load_i,
    input  logic en_i,
    output logic tc_o
);
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYC - 1);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    // Load has priority so the count always starts from zero on entry to user play
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + TW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == LAST);

endmodule

// File: rtl/game_seq_ctrl.sv
// Main controller FSM for the sequence-memory game: playback, user entry, compare, scoring.
// Define GAME_CTRL_LIVES_EN to add a lives budget with a RETRY state and lives_left output.
module game_seq_ctrl #(
    parameter int ROUNDS_MAX  = 16,
    parameter int TIMEOUT_CYC = 50000000
`ifdef GAME_CTRL_LIVES_EN
   ,parameter int LIVES       = 3
`endif
) (
    input  logic            clock,
    input  logic            reset,
    game_seq_ctrl_if.slave  bus
);
    import game_pkg::*;

    localparam int RW = $clog2(ROUNDS_MAX + 1);
    localparam logic [RW-1:0] ROUNDS_W = RW'(ROUNDS_MAX);

    state_e        state_q;
    state_e        state_d;
    logic [RW-1:0] round_q;
    logic [RW-1:0] round_d;
    logic          timed_out_q;
    logic          timed_out_d;
    logic          tc_s;
    logic          miss_s;
    logic          timeout_s;
    logic          last_round_s;
    state_e        miss_dest_s;

`ifdef GAME_CTRL_LIVES_EN
    localparam int LW = $clog2(LIVES + 1);
    localparam logic [LW-1:0] LIVES_W = LW'(LIVES);
    logic [LW-1:0] lives_q;
    logic [LW-1:0] lives_d;
`endif

    game_timeout_cnt #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
        .clock  (clock),
        .reset  (reset),
        .load_i (state_q == ST_PLAY_FPGA),
        .en_i   (state_q == ST_PLAY_USER),
        .tc_o   (tc_s)
    );

    assign last_round_s = ((round_q + RW'(1)) == ROUNDS_W);

    // A miss either retries the same round while lives remain, or ends the game
    always_comb begin
`ifdef GAME_CTRL_LIVES_EN
        if (lives_q > LW'(1)) begin
            miss_dest_s = ST_RETRY;
        end else begin
            miss_dest_s = ST_RESULT;
        end
`else
        miss_dest_s = ST_RESULT;
`endif
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        miss_s    = 1'b0;
        timeout_s = 1'b0;
        case (state_q)
            ST_INIT:       state_d = ST_SETUP;
            ST_SETUP:      state_d = bus.enter ? ST_PLAY_FPGA : ST_SETUP;
            ST_PLAY_FPGA:  state_d = bus.end_fpga ? ST_PLAY_USER : ST_PLAY_FPGA;
            ST_PLAY_USER: begin
                if (bus.end_user) begin
                    state_d = ST_CHECK;
                end else if (tc_s) begin
                    state_d   = miss_dest_s;
                    miss_s    = 1'b1;
                    timeout_s = 1'b1;
                end else begin
                    state_d = ST_PLAY_USER;
                end
            end
            ST_CHECK: begin
                if (bus.match) begin
                    state_d = ST_NEXT_ROUND;
                end else begin
                    state_d = miss_dest_s;
                    miss_s  = 1'b1;
                end
            end
            ST_NEXT_ROUND: state_d = last_round_s ? ST_RESULT : ST_PLAY_FPGA;
            ST_RESULT:     state_d = bus.enter ? ST_INIT : ST_RESULT;
`ifdef GAME_CTRL_LIVES_EN
            ST_RETRY:      state_d = ST_PLAY_FPGA;
`endif
            default:       state_d = ST_INIT;
        endcase
    end

    // Round, timeout-flag and lives updates; entering INIT restores game start values
    always_comb begin
        round_d     = round_q;
        timed_out_d = timed_out_q;
        if (state_d == ST_INIT) begin
            round_d     = '0;
            timed_out_d = 1'b0;
        end else begin
            if ((state_q == ST_NEXT_ROUND) && (round_q != ROUNDS_W)) begin
                round_d = round_q + RW'(1);
            end else begin
                round_d = round_q;
            end
            if (miss_s) begin
                timed_out_d = timeout_s;
            end else begin
                timed_out_d = timed_out_q;
            end
        end
`ifdef GAME_CTRL_LIVES_EN
        lives_d = lives_q;
        if (state_d == ST_INIT) begin
            lives_d = LIVES_W;
        end else if (miss_s && (lives_q != LW'(0))) begin
            lives_d = lives_q - LW'(1);
        end else begin
            lives_d = lives_q;
        end
`endif
    end

    // State and game registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_INIT;
            round_q     <= '0;
            timed_out_q <= 1'b0;
`ifdef GAME_CTRL_LIVES_EN
            lives_q     <= LIVES_W;
`endif
        end else begin
            state_q     <= state_d;
            round_q     <= round_d;
            timed_out_q <= timed_out_d;
`ifdef GAME_CTRL_LIVES_EN
            lives_q     <= lives_d;
`endif
        end
    end

    // Moore strobe decode, one strobe per state
    always_comb begin
        bus.clr_all    = 1'b0;
        bus.clr_user   = 1'b0;
        bus.en_setup   = 1'b0;
        bus.en_fpga    = 1'b0;
        bus.en_user    = 1'b0;
        bus.en_check   = 1'b0;
        bus.sel_result = 1'b0;
        case (state_q)
            ST_INIT:       bus.clr_all    = 1'b1;
            ST_SETUP:      bus.en_setup   = 1'b1;
            ST_PLAY_FPGA:  bus.en_fpga    = 1'b1;
            ST_PLAY_USER:  bus.en_user    = 1'b1;
            ST_CHECK:      bus.en_check   = 1'b1;
            ST_NEXT_ROUND: bus.clr_user   = 1'b1;
            ST_RESULT:     bus.sel_result = 1'b1;
`ifdef GAME_CTRL_LIVES_EN
            ST_RETRY:      bus.clr_user   = 1'b1;
`endif
            default:       bus.clr_all    = 1'b0;
        endcase
    end

    assign bus.round     = round_q;
    assign bus.won       = (state_q == ST_RESULT) && (round_q == ROUNDS_W);
    assign bus.timed_out = timed_out_q;
`ifdef GAME_CTRL_LIVES_EN
    assign bus.lives_left = lives_q;
`endif

endmodule

// File: tb/tb_game_seq_ctrl.sv
// Directed self-checking bench for game_seq_ctrl (ROUNDS_MAX=4, TIMEOUT_CYC=8, LIVES=2).
module tb_game_seq_ctrl;

    localparam int RMAX = 4;
    localparam int TCYC = 8;
    localparam int RW   = $clog2(RMAX + 1);

    // {clr_all, clr_user, en_setup, en_fpga, en_user, en_check, sel_result}
    localparam logic [6:0] S_INIT   = 7'b1000000;
    localparam logic [6:0] S_SETUP  = 7'b0010000;
    localparam logic [6:0] S_FPGA   = 7'b0001000;
    localparam logic [6:0] S_USER   = 7'b0000100;
    localparam logic [6:0] S_CHECK  = 7'b0000010;
    localparam logic [6:0] S_NEXT   = 7'b0100000;
    localparam logic [6:0] S_RESULT = 7'b0000001;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

`ifdef GAME_CTRL_LIVES_EN
    game_seq_ctrl_if #(.RW(RW), .LW(2)) bus ();
    game_seq_ctrl #(.ROUNDS_MAX(RMAX), .TIMEOUT_CYC(TCYC), .LIVES(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );
`else
    game_seq_ctrl_if #(.RW(RW)) bus ();
    game_seq_ctrl #(.ROUNDS_MAX(RMAX), .TIMEOUT_CYC(TCYC)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );
`endif

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [6:0] strb();
        return {bus.clr_all, bus.clr_user, bus.en_setup, bus.en_fpga,
                bus.en_user, bus.en_check, bus.sel_result};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // From INIT: through SETUP and PLAY_FPGA into PLAY_USER
    task automatic go_to_user();
        step();
        chk("setup", 32'(strb()), 32'(S_SETUP));
        bus.enter = 1'b1;
        step();
        bus.enter = 1'b0;
        chk("play_fpga", 32'(strb()), 32'(S_FPGA));
        bus.end_fpga = 1'b1;
        step();
        bus.end_fpga = 1'b0;
        chk("play_user", 32'(strb()), 32'(S_USER));
    endtask

    // From PLAY_USER: one matching move, ending back in PLAY_USER of the next round
    task automatic win_round(input int exp_round);
        bus.end_user = 1'b1;
        bus.match    = 1'b1;
        step();
        bus.end_user = 1'b0;
        chk("win_check", 32'(strb()), 32'(S_CHECK));
        step();
        bus.match = 1'b0;
        chk("win_next", 32'(strb()), 32'(S_NEXT));
        step();
        chk("win_fpga", 32'(strb()), 32'(S_FPGA));
        chk("win_round", 32'(bus.round), 32'(exp_round));
        bus.end_fpga = 1'b1;
        step();
        bus.end_fpga = 1'b0;
        chk("win_user", 32'(strb()), 32'(S_USER));
    endtask

    // Seven idle cycles in PLAY_USER stay there; the eighth times out
    task automatic idle_user();
        for (int i = 0; i < TCYC - 1; i++) begin
            step();
            chk("user_hold", 32'(strb()), 32'(S_USER));
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        reset        = 1'b1;
        bus.enter    = 1'b0;
        bus.end_fpga = 1'b0;
        bus.end_user = 1'b0;
        bus.match    = 1'b0;

        // 1: reset held three cycles
        repeat (3) step();
        chk("rst_strb", 32'(strb()), 32'(S_INIT));
        chk("rst_round", 32'(bus.round), 32'd0);
        chk("rst_won", 32'(bus.won), 32'd0);
        chk("rst_to", 32'(bus.timed_out), 32'd0);
`ifdef GAME_CTRL_LIVES_EN
        chk("rst_lives", 32'(bus.lives_left), 32'd2);
`endif
        reset = 1'b0;
        step();
        chk("setup1", 32'(strb()), 32'(S_SETUP));
        step();
        chk("setup_hold", 32'(strb()), 32'(S_SETUP));
        bus.enter = 1'b1;
        step();
        bus.enter = 1'b0;
        chk("fpga1", 32'(strb()), 32'(S_FPGA));
        step();
        chk("fpga_hold", 32'(strb()), 32'(S_FPGA));
        bus.end_fpga = 1'b1;
        step();
        bus.end_fpga = 1'b0;
        chk("user1", 32'(strb()), 32'(S_USER));

        // 2: win all four rounds
        for (int r = 1; r < RMAX; r++) begin
            win_round(r);
        end
        bus.end_user = 1'b1;
        bus.match    = 1'b1;
        step();
        bus.end_user = 1'b0;
        chk("last_check", 32'(strb()), 32'(S_CHECK));
        step();
        bus.match = 1'b0;
        chk("last_next", 32'(strb()), 32'(S_NEXT));
        chk("last_next_round", 32'(bus.round), 32'd3);
        step();
        chk("win_result", 32'(strb()), 32'(S_RESULT));
        chk("win_round4", 32'(bus.round), 32'd4);
        chk("win_won", 32'(bus.won), 32'd1);
        repeat (2) step();
        chk("result_hold", 32'(strb()), 32'(S_RESULT));
        chk("result_hold_won", 32'(bus.won), 32'd1);
        chk("result_hold_round", 32'(bus.round), 32'd4);
        bus.enter = 1'b1;
        step();
        bus.enter = 1'b0;
        chk("ack_init", 32'(strb()), 32'(S_INIT));
        chk("ack_round", 32'(bus.round), 32'd0);
        chk("ack_won", 32'(bus.won), 32'd0);

        // 3: user never finishes -> timeout after exactly 8 cycles
        go_to_user();
        idle_user();
        step();
`ifdef GAME_CTRL_LIVES_EN
        chk("to_retry", 32'(strb()), 32'(S_NEXT));
        chk("to_lives1", 32'(bus.lives_left), 32'd1);
        chk("to_flag1", 32'(bus.timed_out), 32'd1);
        step();
        chk("to_refpga", 32'(strb()), 32'(S_FPGA));
        bus.end_fpga = 1'b1;
        step();
        bus.end_fpga = 1'b0;
        chk("to_reuser", 32'(strb()), 32'(S_USER));
        idle_user();
        step();
        chk("to_lives0", 32'(bus.lives_left), 32'd0);
`endif
        chk("to_result", 32'(strb()), 32'(S_RESULT));
        chk("to_flag", 32'(bus.timed_out), 32'd1);
        chk("to_won", 32'(bus.won), 32'd0);
        chk("to_round", 32'(bus.round), 32'd0);
        bus.enter = 1'b1;
        step();
        bus.enter = 1'b0;
        chk("to_init", 32'(strb()), 32'(S_INIT));
        chk("to_cleared", 32'(bus.timed_out), 32'd0);

        // 4: end_user on the terminal-count cycle wins over timeout
        go_to_user();
        idle_user();
        bus.end_user = 1'b1;
        bus.match    = 1'b1;
        step();
        bus.end_user = 1'b0;
        chk("tie_check", 32'(strb()), 32'(S_CHECK));
        chk("tie_flag", 32'(bus.timed_out), 32'd0);
        step();
        bus.match = 1'b0;
        chk("tie_next", 32'(strb()), 32'(S_NEXT));
        step();
        chk("tie_fpga", 32'(strb()), 32'(S_FPGA));
        chk("tie_round", 32'(bus.round), 32'd1);
        bus.end_fpga = 1'b1;
        step();
        bus.end_fpga = 1'b0;

        // 5: reset mid-game at round 2
        win_round(2);
        chk("mid_round2", 32'(bus.round), 32'd2);
        reset = 1'b1;
        step();
        chk("mid_init", 32'(strb()), 32'(S_INIT));
        chk("mid_round0", 32'(bus.round), 32'd0);
        reset = 1'b0;
        step();
        chk("mid_setup", 32'(strb()), 32'(S_SETUP));
        bus.enter = 1'b1;
        step();
        bus.enter = 1'b0;
        bus.end_fpga = 1'b1;
        step();
        bus.end_fpga = 1'b0;
        chk("g6_user", 32'(strb()), 32'(S_USER));

`ifdef GAME_CTRL_LIVES_EN
        // 6: two misses at round 1 with two lives
        chk("l_lives2", 32'(bus.lives_left), 32'd2);
        win_round(1);
        bus.end_user = 1'b1;
        step();
        bus.end_user = 1'b0;
        chk("l_check1", 32'(strb()), 32'(S_CHECK));
        step();
        chk("l_retry", 32'(strb()), 32'(S_NEXT));
        chk("l_lives1", 32'(bus.lives_left), 32'd1);
        chk("l_round1", 32'(bus.round), 32'd1);
        chk("l_flag", 32'(bus.timed_out), 32'd0);
        step();
        chk("l_fpga", 32'(strb()), 32'(S_FPGA));
        bus.end_fpga = 1'b1;
        step();
        bus.end_fpga = 1'b0;
        bus.end_user = 1'b1;
        step();
        bus.end_user = 1'b0;
        chk("l_check2", 32'(strb()), 32'(S_CHECK));
        step();
        chk("l_result", 32'(strb()), 32'(S_RESULT));
        chk("l_lives0", 32'(bus.lives_left), 32'd0);
        chk("l_round_kept", 32'(bus.round), 32'd1);
        chk("l_won", 32'(bus.won), 32'd0);
`else
        // A compare miss ends the game immediately
        bus.end_user = 1'b1;
        bus.match    = 1'b0;
        step();
        bus.end_user = 1'b0;
        chk("miss_check", 32'(strb()), 32'(S_CHECK));
        step();
        chk("miss_result", 32'(strb()), 32'(S_RESULT));
        chk("miss_flag", 32'(bus.timed_out), 32'd0);
        chk("miss_won", 32'(bus.won), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
